// File: rtl/counter_run_ctrl.sv
// Shares one up-counter between two requesters: grants round-robin, enables the
// counter for exactly N ticks, then confirms q advanced by N modulo 2^CW.
//
// state   | meaning
// S_IDLE  | no grant; waiting for any req bit
// S_RUN   | counter enabled (or paused by hold) until rem reaches 0
// S_CHECK | q holds the final value; compare against start + len
// S_GAP   | idle spacing after done before the next grant
module counter_run_ctrl #(
    parameter int CW  = 3,
    parameter int GAP = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [CW-1:0] len0,
    input  logic [CW-1:0] len1,
    input  logic          hold,
    input  logic [CW-1:0] q,
    output logic          cnt_en,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;
    localparam logic [2:0] GAP_LOAD = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

    logic [1:0]    state;
    logic          last;
    logic [CW:0]   rem;
    logic [CW:0]   rem_dec;
    logic [CW-1:0] start;
    logic [CW-1:0] len_q;
    logic [CW-1:0] exp_q;
    logic [2:0]    gap_cnt;
    logic          pick;
    logic [CW-1:0] len_pick;

    // With both requesting, the one not served last time wins.
    always_comb begin
        pick = 1'b0;
        if (req == 2'b11)
            pick = ~last;
        else if (req[1])
            pick = 1'b1;
        len_pick = pick ? len1 : len0;
        rem_dec  = rem - {{CW{1'b0}}, 1'b1};
    end

    // A zero length wraps the full counter, so q must come back to start.
    assign exp_q = start + len_q;
    assign busy  = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            last    <= 1'b1;
            rem     <= '0;
            start   <= '0;
            len_q   <= '0;
            gap_cnt <= '0;
            cnt_en  <= 1'b0;
            gnt     <= 2'b00;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        state  <= S_RUN;
                        last   <= pick;
                        gnt    <= pick ? 2'b10 : 2'b01;
                        start  <= q;
                        len_q  <= len_pick;
                        rem    <= {(len_pick == '0), len_pick};
                        cnt_en <= ~hold;
                    end
                end
                S_RUN: begin
                    if (cnt_en) begin
                        rem <= rem_dec;
                        if (rem_dec == '0) begin
                            state  <= S_CHECK;
                            cnt_en <= 1'b0;
                        end else begin
                            cnt_en <= ~hold;
                        end
                    end else begin
                        cnt_en <= ~hold;
                    end
                end
                S_CHECK: begin
                    done    <= 1'b1;
                    err     <= (q != exp_q);
                    gnt     <= 2'b00;
                    gap_cnt <= GAP_LOAD;
                    state   <= (GAP == 0) ? S_IDLE : S_GAP;
                end
                default: begin
                    if (gap_cnt == '0)
                        state <= S_IDLE;
                    else
                        gap_cnt <= gap_cnt - 3'd1;
                end
            endcase
        end
    end
endmodule
